// File: rtl/cc_score_collector.sv
// rtl/cc_score_collector.sv - collects 7 score beats plus frame fields and presents them as a held parallel frame
module cc_score_collector #(
   parameter int SCORE_W = 4,
   parameter int TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [SCORE_W-1:0] in_score,
   input  logic [2:0]         in_opt,
   input  logic [1:0]         in_a,
   input  logic [2:0]         in_b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [SCORE_W-1:0] in_s0,
   output logic [SCORE_W-1:0] in_s1,
   output logic [SCORE_W-1:0] in_s2,
   output logic [SCORE_W-1:0] in_s3,
   output logic [SCORE_W-1:0] in_s4,
   output logic [SCORE_W-1:0] in_s5,
   output logic [SCORE_W-1:0] in_s6,
   output logic [2:0]         opt,
   output logic [1:0]         a,
   output logic [2:0]         b,
   output logic               err
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_HOLD
   } state_t;

   localparam logic [7:0] IDLE_LIMIT = 8'(TIMEOUT - 1);

   state_t                   state_q, state_d;
   logic [2:0]               cnt_q, cnt_d;
   logic [7:0]               idle_cnt_q, idle_cnt_d;
   logic [6:0][SCORE_W-1:0]  sh_q, sh_d;
   logic [2:0]               sh_opt_q, sh_opt_d;
   logic [1:0]               sh_a_q, sh_a_d;
   logic [2:0]               sh_b_q, sh_b_d;
   logic [6:0][SCORE_W-1:0]  out_s_q, out_s_d;
   logic [2:0]               opt_q, opt_d;
   logic [1:0]               a_q, a_d;
   logic [2:0]               b_q, b_d;
   logic                     out_valid_q, out_valid_d;
   logic                     err_q, err_d;
   logic                     beat;

   assign in_ready = (state_q != ST_HOLD);
   assign beat     = in_valid && in_ready;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idle_cnt_d  = idle_cnt_q;
      sh_d        = sh_q;
      sh_opt_d    = sh_opt_q;
      sh_a_d      = sh_a_q;
      sh_b_d      = sh_b_q;
      out_s_d     = out_s_q;
      opt_d       = opt_q;
      a_d         = a_q;
      b_d         = b_q;
      out_valid_d = out_valid_q;
      err_d       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            idle_cnt_d = 8'd0;
            if (beat) begin
               sh_d[0]  = in_score;
               sh_opt_d = in_opt;
               sh_a_d   = in_a;
               sh_b_d   = in_b;
               cnt_d    = 3'd1;
               state_d  = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (beat) begin
               sh_d[cnt_q] = in_score;
               idle_cnt_d  = 8'd0;
               if (cnt_q == 3'd6) begin
                  // The last score bypasses the shadow so the whole frame lands in one edge.
                  out_s_d     = {in_score, sh_q[5:0]};
                  opt_d       = sh_opt_q;
                  a_d         = sh_a_q;
                  b_d         = sh_b_q;
                  out_valid_d = 1'b1;
                  cnt_d       = 3'd0;
                  state_d     = ST_HOLD;
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end else if (idle_cnt_q == IDLE_LIMIT) begin
               state_d    = ST_IDLE;
               cnt_d      = 3'd0;
               idle_cnt_d = 8'd0;
               err_d      = 1'b1;
            end else begin
               idle_cnt_d = idle_cnt_q + 8'd1;
            end
         end
         ST_HOLD: begin
            idle_cnt_d = 8'd0;
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 3'd0;
         idle_cnt_q  <= 8'd0;
         sh_q        <= '0;
         sh_opt_q    <= 3'd0;
         sh_a_q      <= 2'd0;
         sh_b_q      <= 3'd0;
         out_s_q     <= '0;
         opt_q       <= 3'd0;
         a_q         <= 2'd0;
         b_q         <= 3'd0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idle_cnt_q  <= idle_cnt_d;
         sh_q        <= sh_d;
         sh_opt_q    <= sh_opt_d;
         sh_a_q      <= sh_a_d;
         sh_b_q      <= sh_b_d;
         out_s_q     <= out_s_d;
         opt_q       <= opt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         out_valid_q <= out_valid_d;
         err_q       <= err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign err       = err_q;
   assign in_s0     = out_s_q[0];
   assign in_s1     = out_s_q[1];
   assign in_s2     = out_s_q[2];
   assign in_s3     = out_s_q[3];
   assign in_s4     = out_s_q[4];
   assign in_s5     = out_s_q[5];
   assign in_s6     = out_s_q[6];
   assign opt       = opt_q;
   assign a         = a_q;
   assign b         = b_q;

endmodule
